// File: rtl/bus_pkg.sv
// Shared encodings for the CPU memory bus: command codes, responder FSM states,
// decode targets and default I/O register addresses.
package bus_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RSVD  = 2'b11
  } mem_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ACCESS,
    ST_RESP,
    ST_RELEASE
  } bus_state_e;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_RAM,
    TGT_LED,
    TGT_SW
  } bus_tgt_e;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

  // Reserved encoding behaves exactly like NONE.
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/bus_ram.sv
// Single-port synchronous RAM with a registered read port that holds its value
// between reads and clears on reset (array contents are never cleared).
module bus_ram
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     dout <= '0;
    else if (re) dout <= mem[addr];
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-bus target: decodes each latched request to RAM, the LED register or the
// switch port, and answers with a one-cycle ack inside a 4-phase handshake.
module mem_io_responder
  import bus_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 9,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       RAM_DEPTH   = 256,
  parameter int unsigned       WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] LED_ADDR    = ADDR_W'(LED_ADDR_DEF),
  parameter logic [ADDR_W-1:0] SW_ADDR     = ADDR_W'(SW_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ack,
  output logic              bus_err,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out
);

  localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);
  localparam int unsigned WC_W   = 4;

  bus_state_e        state_q, state_d;
  logic [1:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [WC_W-1:0]   wait_cnt;
  logic [7:0]        sw_meta, sw_sync;
  logic [DATA_W-1:0] io_rd, ram_dout;
  logic              rd_sel_ram;

  bus_tgt_e tgt_c;
  logic     accept_c, is_rd_c, is_wr_c;
  logic     ram_we_c, ram_re_c, led_we_c, rd_load_c, ack_d, err_d;

  assign accept_c = (state_q == ST_IDLE) && is_req(mem_cmd);
  assign is_rd_c  = (req_cmd == CMD_READ);
  assign is_wr_c  = (req_cmd == CMD_WRITE);

  // Address decode always works on the latched request.
  always_comb begin
    tgt_c = TGT_NONE;
    if (32'(req_addr) < RAM_DEPTH) tgt_c = TGT_RAM;
    else if (req_addr == LED_ADDR) tgt_c = TGT_LED;
    else if (req_addr == SW_ADDR)  tgt_c = TGT_SW;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (is_req(mem_cmd)) state_d = (WAIT_STATES > 0) ? ST_BUSY : ST_ACCESS;
      ST_BUSY:    if (wait_cnt <= WC_W'(1)) state_d = ST_ACCESS;
      ST_ACCESS:  state_d = ST_RESP;
      ST_RESP:    state_d = ST_RELEASE;
      ST_RELEASE: if (!is_req(mem_cmd)) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Side effects of the ACCESS cycle; ack/err are registered into RESP.
  always_comb begin
    ram_we_c  = 1'b0;
    ram_re_c  = 1'b0;
    led_we_c  = 1'b0;
    rd_load_c = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    if (state_q == ST_ACCESS) begin
      ack_d = 1'b1;
      case (tgt_c)
        TGT_RAM: begin
          ram_we_c = is_wr_c;
          ram_re_c = is_rd_c;
        end
        TGT_LED: led_we_c = is_wr_c;
        TGT_SW:  err_d    = is_wr_c;
        default: err_d    = 1'b1;
      endcase
      rd_load_c = is_rd_c && (tgt_c != TGT_NONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_cmd    <= CMD_NONE;
      req_addr   <= '0;
      req_data   <= '0;
      wait_cnt   <= '0;
      mem_ack    <= 1'b0;
      bus_err    <= 1'b0;
      led_out    <= '0;
      sw_meta    <= '0;
      sw_sync    <= '0;
      io_rd      <= '0;
      rd_sel_ram <= 1'b0;
    end else begin
      mem_ack <= ack_d;
      bus_err <= err_d;
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      if (accept_c) begin
        req_cmd  <= mem_cmd;
        req_addr <= mem_addr;
        req_data <= write_data;
        wait_cnt <= WC_W'(WAIT_STATES);
      end else if (state_q == ST_BUSY) begin
        wait_cnt <= wait_cnt - WC_W'(1);
      end
      if (led_we_c) led_out <= req_data[7:0];
      // Read source is chosen only by reads that hit a legal target.
      if (rd_load_c) begin
        rd_sel_ram <= (tgt_c == TGT_RAM);
        if (tgt_c == TGT_LED)     io_rd <= DATA_W'(led_out);
        else if (tgt_c == TGT_SW) io_rd <= DATA_W'(sw_sync);
      end
    end
  end

  assign read_data = rd_sel_ram ? ram_dout : io_rd;

  bus_ram #(
    .DEPTH  (RAM_DEPTH),
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk  (clk),
    .rst  (reset),
    .we   (ram_we_c),
    .re   (ram_re_c),
    .addr (req_addr[RAM_AW-1:0]),
    .din  (req_data),
    .dout (ram_dout)
  );

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: two instances (0 and 3 wait states) driven by
// directed scenarios and random traffic, checked against a behavioural bus model.
`timescale 1ns/1ps
module tb_mem_io_responder;
  import bus_pkg::*;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd_s   [2];
  logic [8:0]  addr_s  [2];
  logic [15:0] wdata_s [2];
  logic [15:0] rdata_s [2];
  logic        ack_s   [2];
  logic        err_s   [2];
  logic [7:0]  sw_s    [2];
  logic [7:0]  led_s   [2];

  int errors = 0;
  int checks = 0;

  // Behavioural model: memory image, LED value and last read result per instance.
  logic [15:0] ram_m [2][256];
  bit          ram_v [2][256];
  logic [7:0]  led_m [2];
  logic [15:0] rd_m  [2];

  always #5 clk = ~clk;

  mem_io_responder #(.WAIT_STATES(WS0)) dut0 (
    .clk(clk), .reset(reset), .mem_cmd(cmd_s[0]), .mem_addr(addr_s[0]),
    .write_data(wdata_s[0]), .read_data(rdata_s[0]), .mem_ack(ack_s[0]),
    .bus_err(err_s[0]), .sw_in(sw_s[0]), .led_out(led_s[0])
  );

  mem_io_responder #(.WAIT_STATES(WS1)) dut3 (
    .clk(clk), .reset(reset), .mem_cmd(cmd_s[1]), .mem_addr(addr_s[1]),
    .write_data(wdata_s[1]), .read_data(rdata_s[1]), .mem_ack(ack_s[1]),
    .bus_err(err_s[1]), .sw_in(sw_s[1]), .led_out(led_s[1])
  );

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  task automatic model_txn(input int d, input logic [1:0] cmd, input logic [8:0] addr,
                           input logic [15:0] data, output logic err_e, output logic [15:0] rd_e);
    bit wr;
    wr    = (cmd == CMD_WRITE);
    err_e = 1'b0;
    if (addr < 9'd256) begin
      if (wr) begin
        ram_m[d][addr[7:0]] = data;
        ram_v[d][addr[7:0]] = 1'b1;
      end else begin
        rd_m[d] = ram_m[d][addr[7:0]];
      end
    end else if (addr == 9'h100) begin
      if (wr) led_m[d] = data[7:0];
      else    rd_m[d] = {8'h00, led_m[d]};
    end else if (addr == 9'h140 && !wr) begin
      rd_m[d] = {8'h00, sw_s[d]};
    end else begin
      err_e = 1'b1;
    end
    rd_e = rd_m[d];
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      led_m[d] = 8'h00;
      rd_m[d]  = 16'h0000;
    end
  endtask

  // Issues one request, holds it `hold` cycles past the ack, then releases.
  // Address/data are scrambled after acceptance to prove the request is latched.
  task automatic run_txn(input int d, input logic [1:0] cmd, input logic [8:0] addr,
                         input logic [15:0] data, input int hold, output int ack_at,
                         output int pulses, output logic err, output logic [15:0] rd);
    cmd_s[d] = cmd; addr_s[d] = addr; wdata_s[d] = data;
    ack_at = -1; pulses = 0; err = 1'bx; rd = 16'hxxxx;
    for (int n = 1; n <= 40 && ack_at < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        addr_s[d]  = 9'($urandom);
        wdata_s[d] = 16'($urandom);
      end
      if (ack_s[d] === 1'b1) begin
        ack_at = n; pulses++; err = err_s[d]; rd = rdata_s[d];
      end
    end
    for (int n = 0; n < hold; n++) begin
      @(negedge clk);
      if (ack_s[d] !== 1'b0) pulses++;
    end
    cmd_s[d] = CMD_NONE;
    repeat (2) begin
      @(negedge clk);
      if (ack_s[d] !== 1'b0) pulses++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cmd_s[d] = CMD_NONE; addr_s[d] = '0; wdata_s[d] = '0; sw_s[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (ack_s[d] !== 1'b0)      begin errors++; $display("FAIL reset_ack d%0d: got %b want 0", d, ack_s[d]); end
      checks++; if (err_s[d] !== 1'b0)      begin errors++; $display("FAIL reset_err d%0d: got %b want 0", d, err_s[d]); end
      checks++; if (rdata_s[d] !== 16'h0)   begin errors++; $display("FAIL reset_rdata d%0d: got %h want 0000", d, rdata_s[d]); end
      checks++; if (led_s[d] !== 8'h0)      begin errors++; $display("FAIL reset_led d%0d: got %h want 00", d, led_s[d]); end
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_ram_rw();
    int at, np; logic e, ee; logic [15:0] r, re;
    for (int d = 0; d < 2; d++) begin
      run_txn(d, CMD_WRITE, 9'h00A, 16'hBEEF, 0, at, np, e, r);
      model_txn(d, CMD_WRITE, 9'h00A, 16'hBEEF, ee, re);
      checks++; if (at != ws_of(d) + 2) begin errors++; $display("FAIL wr_latency d%0d: got %0d want %0d", d, at, ws_of(d) + 2); end
      checks++; if (e !== 1'b0)         begin errors++; $display("FAIL wr_err d%0d: got %b want 0", d, e); end
      run_txn(d, CMD_READ, 9'h00A, 16'h0, 0, at, np, e, r);
      model_txn(d, CMD_READ, 9'h00A, 16'h0, ee, re);
      checks++; if (at != ws_of(d) + 2) begin errors++; $display("FAIL rd_latency d%0d: got %0d want %0d", d, at, ws_of(d) + 2); end
      checks++; if (r !== 16'hBEEF)     begin errors++; $display("FAIL rd_data d%0d: got %h want beef", d, r); end
      checks++; if (e !== 1'b0)         begin errors++; $display("FAIL rd_err d%0d: got %b want 0", d, e); end
    end
  endtask

  task automatic test_wait_hold();
    int at, np; logic e, ee; logic [15:0] r, re, v;
    v = 16'($urandom);
    run_txn(1, CMD_WRITE, 9'h000, v, 0, at, np, e, r);
    model_txn(1, CMD_WRITE, 9'h000, v, ee, re);
    run_txn(1, CMD_READ, 9'h000, 16'h0, 4, at, np, e, r);
    model_txn(1, CMD_READ, 9'h000, 16'h0, ee, re);
    checks++; if (at != 5)  begin errors++; $display("FAIL hold_latency: got %0d want 5", at); end
    checks++; if (np != 1)  begin errors++; $display("FAIL hold_pulses: got %0d want 1", np); end
    checks++; if (r !== re) begin errors++; $display("FAIL hold_rdata: got %h want %h", r, re); end
    run_txn(1, CMD_READ, 9'h000, 16'h0, 0, at, np, e, r);
    checks++; if (at != 5)  begin errors++; $display("FAIL reissue_latency: got %0d want 5", at); end
  endtask

  task automatic test_io();
    int at, np; logic e, ee; logic [15:0] r, re;
    for (int d = 0; d < 2; d++) begin
      run_txn(d, CMD_WRITE, 9'h100, 16'h12A5, 0, at, np, e, r);
      model_txn(d, CMD_WRITE, 9'h100, 16'h12A5, ee, re);
      checks++; if (led_s[d] !== 8'hA5) begin errors++; $display("FAIL led_write d%0d: got %h want a5", d, led_s[d]); end
      checks++; if (e !== 1'b0)         begin errors++; $display("FAIL led_err d%0d: got %b want 0", d, e); end
      run_txn(d, CMD_READ, 9'h100, 16'h0, 0, at, np, e, r);
      model_txn(d, CMD_READ, 9'h100, 16'h0, ee, re);
      checks++; if (r !== 16'h00A5)     begin errors++; $display("FAIL led_read d%0d: got %h want 00a5", d, r); end
      sw_s[d] = 8'h3C;
      repeat (3) @(negedge clk);
      run_txn(d, CMD_READ, 9'h140, 16'h0, 0, at, np, e, r);
      model_txn(d, CMD_READ, 9'h140, 16'h0, ee, re);
      checks++; if (r !== 16'h003C)     begin errors++; $display("FAIL sw_read d%0d: got %h want 003c", d, r); end
      checks++; if (e !== 1'b0)         begin errors++; $display("FAIL sw_err d%0d: got %b want 0", d, e); end
    end
  endtask

  task automatic test_bus_err();
    int at, np; logic e, ee; logic [15:0] r, re, v;
    logic [8:0] bad [3];
    logic [1:0] bcmd [3];
    bad[0] = 9'h180; bad[1] = 9'h140; bad[2] = 9'h1FF;
    bcmd[0] = CMD_WRITE; bcmd[1] = CMD_WRITE; bcmd[2] = CMD_READ;
    for (int d = 0; d < 2; d++) begin
      v = 16'($urandom);
      run_txn(d, CMD_WRITE, 9'h080, v, 0, at, np, e, r);
      model_txn(d, CMD_WRITE, 9'h080, v, ee, re);
      for (int k = 0; k < 3; k++) begin
        run_txn(d, bcmd[k], bad[k], 16'hFFFF, 0, at, np, e, r);
        model_txn(d, bcmd[k], bad[k], 16'hFFFF, ee, re);
        checks++; if (at != ws_of(d) + 2) begin errors++; $display("FAIL err_latency d%0d a=%h: got %0d want %0d", d, bad[k], at, ws_of(d) + 2); end
        checks++; if (e !== 1'b1)         begin errors++; $display("FAIL err_flag d%0d a=%h: got %b want 1", d, bad[k], e); end
        checks++; if (r !== re)           begin errors++; $display("FAIL err_rdata d%0d a=%h: got %h want %h", d, bad[k], r, re); end
        checks++; if (led_s[d] !== led_m[d]) begin errors++; $display("FAIL err_led d%0d a=%h: got %h want %h", d, bad[k], led_s[d], led_m[d]); end
      end
      run_txn(d, CMD_READ, 9'h080, 16'h0, 0, at, np, e, r);
      model_txn(d, CMD_READ, 9'h080, 16'h0, ee, re);
      checks++; if (r !== re) begin errors++; $display("FAIL err_ram_intact d%0d: got %h want %h", d, r, re); end
    end
  endtask

  task automatic test_reset_mid();
    int at, np; logic e, ee; logic [15:0] r, re;
    int seen;
    run_txn(1, CMD_WRITE, 9'h005, 16'h2222, 0, at, np, e, r);
    model_txn(1, CMD_WRITE, 9'h005, 16'h2222, ee, re);
    cmd_s[1] = CMD_WRITE; addr_s[1] = 9'h005; wdata_s[1] = 16'h1111;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (ack_s[1] !== 1'b0) seen++;
    end
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (ack_s[d] !== 1'b0)    begin errors++; $display("FAIL midrst_ack d%0d: got %b want 0", d, ack_s[d]); end
      checks++; if (rdata_s[d] !== 16'h0) begin errors++; $display("FAIL midrst_rdata d%0d: got %h want 0000", d, rdata_s[d]); end
      checks++; if (led_s[d] !== 8'h0)    begin errors++; $display("FAIL midrst_led d%0d: got %h want 00", d, led_s[d]); end
    end
    cmd_s[1] = CMD_NONE;
    repeat (2) begin
      @(negedge clk);
      if (ack_s[1] !== 1'b0) seen++;
    end
    reset = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      if (ack_s[1] !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_ack: got %0d acks want 0", seen); end
    run_txn(1, CMD_READ, 9'h005, 16'h0, 0, at, np, e, r);
    model_txn(1, CMD_READ, 9'h005, 16'h0, ee, re);
    checks++; if (r !== 16'h2222) begin errors++; $display("FAIL midrst_ram d1: got %h want 2222", r); end
    checks++; if (at != 5)        begin errors++; $display("FAIL midrst_latency: got %0d want 5", at); end
  endtask

  task automatic test_rsvd_and_drop();
    int at, np, seen; logic e, ee; logic [15:0] r, re;
    for (int d = 0; d < 2; d++) begin
      cmd_s[d] = CMD_RSVD; addr_s[d] = 9'h00A;
      seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (ack_s[d] !== 1'b0) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL rsvd_ack d%0d: got %0d acks want 0", d, seen); end
      run_txn(d, CMD_READ, 9'h00A, 16'h0, 0, at, np, e, r);
      model_txn(d, CMD_READ, 9'h00A, 16'h0, ee, re);
      checks++; if (at != ws_of(d) + 2) begin errors++; $display("FAIL rsvd_then_read d%0d: got %0d want %0d", d, at, ws_of(d) + 2); end
    end
    // Command withdrawn during BUSY still completes.
    cmd_s[1] = CMD_READ; addr_s[1] = 9'h00A;
    at = -1;
    for (int n = 1; n <= 40 && at < 0; n++) begin
      @(negedge clk);
      if (n == 1) cmd_s[1] = CMD_NONE;
      if (ack_s[1] === 1'b1) begin at = n; r = rdata_s[1]; end
    end
    model_txn(1, CMD_READ, 9'h00A, 16'h0, ee, re);
    checks++; if (at != 5)  begin errors++; $display("FAIL drop_latency: got %0d want 5", at); end
    checks++; if (r !== re) begin errors++; $display("FAIL drop_rdata: got %h want %h", r, re); end
    @(negedge clk);
    @(negedge clk);
    run_txn(1, CMD_READ, 9'h005, 16'h0, 0, at, np, e, r);
    model_txn(1, CMD_READ, 9'h005, 16'h0, ee, re);
    checks++; if (at != 5)  begin errors++; $display("FAIL drop_next_latency: got %0d want 5", at); end
    checks++; if (r !== re) begin errors++; $display("FAIL drop_next_rdata: got %h want %h", r, re); end
  endtask

  task automatic test_random();
    int at, np, d, kind, hold; logic e, ee; logic [15:0] r, re, v;
    logic [8:0] a; logic [1:0] c;
    for (int i = 0; i < 60; i++) begin
      d = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      hold = int'($urandom_range(0, 2));
      v = 16'($urandom);
      a = 9'($urandom_range(0, 255));
      c = CMD_WRITE;
      if (kind >= 5 && kind <= 6) begin
        if (ram_v[d][a[7:0]]) c = CMD_READ;
      end else if (kind == 7) begin
        a = 9'h100;
        c = ($urandom_range(0, 1) == 0) ? CMD_READ : CMD_WRITE;
      end else if (kind == 8) begin
        a = 9'h140; c = CMD_READ;
        sw_s[d] = 8'($urandom);
        repeat (3) @(negedge clk);
      end else if (kind == 9) begin
        a = 9'($urandom_range(257, 511));
        if (a == 9'h140) a = 9'h1FF;
        c = ($urandom_range(0, 1) == 0) ? CMD_READ : CMD_WRITE;
      end
      run_txn(d, c, a, v, hold, at, np, e, r);
      model_txn(d, c, a, v, ee, re);
      checks++; if (at != ws_of(d) + 2) begin errors++; $display("FAIL rnd_latency #%0d d%0d: got %0d want %0d", i, d, at, ws_of(d) + 2); end
      checks++; if (np != 1)            begin errors++; $display("FAIL rnd_pulses #%0d d%0d: got %0d want 1", i, d, np); end
      checks++; if (e !== ee)           begin errors++; $display("FAIL rnd_err #%0d d%0d a=%h: got %b want %b", i, d, a, e, ee); end
      checks++; if (r !== re)           begin errors++; $display("FAIL rnd_rdata #%0d d%0d a=%h: got %h want %h", i, d, a, r, re); end
      checks++; if (led_s[d] !== led_m[d]) begin errors++; $display("FAIL rnd_led #%0d d%0d: got %h want %h", i, d, led_s[d], led_m[d]); end
    end
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_wait_hold();
    test_io();
    test_bus_err();
    test_reset_mid();
    test_rsvd_and_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
